// File: rtl/cdb_arbiter_rr.sv
// Common-data-bus arbiter: round-robin over NUM_CH EU result ports with an optional
// fixed-priority channel, a starvation guard and one registered valid/ready output stage.
package expipe_pkg;
  localparam int EU_N           = 6;
  localparam int EU_LOAD_BUFFER = 1;

  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [31:0] res_value;
    logic        except_raised;
    logic [4:0]  except_code;
    logic [3:0]  flags;
  } cdb_data_t;

  localparam int CDB_W = $bits(cdb_data_t);
endpackage

// Per-channel request qualification: masked request and "at or above the RR pointer" view.
module cdb_arb_lane #(
  parameter int IDX = 0,
  parameter int PW  = 1
) (
  input  logic          valid,
  input  logic          excl,
  input  logic [PW-1:0] ptr,
  output logic          req,
  output logic          req_hi
);
  assign req    = valid & ~excl;
  assign req_hi = req & (IDX >= int'(ptr));
endmodule

module cdb_arbiter_rr #(
  parameter int NUM_CH     = expipe_pkg::EU_N,
  parameter bit PRIO_EN    = 1'b1,
  parameter int PRIO_CH    = expipe_pkg::EU_LOAD_BUFFER,
  parameter int STARVE_MAX = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     flush_i,
  input  logic [NUM_CH-1:0]                        eu_valid_i,
  output logic [NUM_CH-1:0]                        eu_ready_o,
  input  logic [NUM_CH-1:0][expipe_pkg::CDB_W-1:0] eu_data_i,
  output logic                                     cdb_valid_o,
  input  logic                                     cdb_ready_i,
  output logic [expipe_pkg::CDB_W-1:0]             cdb_data_o,
  output logic [$clog2(NUM_CH)-1:0]                cdb_src_o
);
  localparam int            SW       = $clog2(NUM_CH);
  localparam int            CW       = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STARVE_MAX);
  localparam logic [SW-1:0] PRIO_IDX = SW'(PRIO_CH);
  localparam logic [SW-1:0] LAST_IDX = SW'(NUM_CH - 1);

  logic [SW-1:0]     rr_ptr;
  logic [CW-1:0]     starve_cnt;
  logic              acc, arb_en, starve_force;
  logic              prio_vld, others_vld, prio_win, gnt_any, gnt_is_prio;
  logic [NUM_CH-1:0] prio_mask, req, req_hi;
  logic [SW-1:0]     gnt_idx, hi_idx, lo_idx;

  assign acc          = ~cdb_valid_o | cdb_ready_i;
  assign arb_en       = acc & ~flush_i & ~rst_i;
  assign starve_force = (starve_cnt == CNT_MAX);
  assign prio_mask    = PRIO_EN ? (NUM_CH'(1) << PRIO_CH) : '0;
  assign prio_vld     = |(eu_valid_i & prio_mask);
  assign others_vld   = |(eu_valid_i & ~prio_mask);
  assign prio_win     = prio_vld & ~starve_force;

  // The priority channel is dropped from the search only when someone else can win,
  // so a lone priority request is still served while the guard is armed.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    cdb_arb_lane #(.IDX(i), .PW(SW)) u_lane (
      .valid  (eu_valid_i[i]),
      .excl   (prio_mask[i] & starve_force & others_vld),
      .ptr    (rr_ptr),
      .req    (req[i]),
      .req_hi (req_hi[i])
    );
  end

  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_hi[i]) hi_idx = SW'(i);
      if (req[i])    lo_idx = SW'(i);
    end
    gnt_any     = prio_win | (|req);
    gnt_idx     = prio_win ? PRIO_IDX : ((|req_hi) ? hi_idx : lo_idx);
    gnt_is_prio = prio_mask[gnt_idx];
    eu_ready_o  = '0;
    if (arb_en && gnt_any) eu_ready_o[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cdb_valid_o <= 1'b0;
      cdb_data_o  <= '0;
      cdb_src_o   <= '0;
      rr_ptr      <= '0;
      starve_cnt  <= '0;
    end else if (flush_i) begin
      cdb_valid_o <= 1'b0;
      starve_cnt  <= '0;
    end else if (acc) begin
      cdb_valid_o <= gnt_any;
      if (gnt_any) begin
        cdb_data_o <= eu_data_i[gnt_idx];
        cdb_src_o  <= gnt_idx;
        if (!gnt_is_prio) begin
          rr_ptr     <= (gnt_idx == LAST_IDX) ? '0 : SW'(gnt_idx + 1'b1);
          starve_cnt <= '0;
        end else if (others_vld && !starve_force) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/cdb_arbiter_rr.md
Name: cdb_arbiter_rr

Overview:
- Parametrised common-data-bus arbiter between NUM_CH execution-unit result ports and the single CDB consumed by the ROB, the reservation stations and register status.
- Round-robin arbitration with one optional fixed-priority channel (load buffer by default).
- A starvation guard bounds how long the priority channel can block the others.
- One registered output stage with valid/ready backpressure from the ROB.

Parameters:
- NUM_CH, expipe_pkg::EU_N, number of requesting EU channels (>=2).
- PRIO_EN, 1, enable fixed-priority channel.
- PRIO_CH, 1 (EU_LOAD_BUFFER), index of the priority channel; ignored if PRIO_EN=0.
- STARVE_MAX, 4, cycles a non-priority request may be blocked by the priority channel before it is forced to win (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  pipeline flush (mispredict/exception).
- eu_valid_i  in  NUM_CH  per-channel result valid.
- eu_ready_o  out  NUM_CH  per-channel grant/accept, one-hot or zero.
- eu_data_i  in  NUM_CH x $bits(cdb_data_t)  per-channel result (rob_idx, res_value, except_raised, except_code, flags).
- cdb_valid_o  out  1  CDB word valid.
- cdb_ready_i  in  1  consumer (ROB) ready.
- cdb_data_o  out  $bits(cdb_data_t)  CDB word.
- cdb_src_o  out  $clog2(NUM_CH)  index of the channel that produced cdb_data_o.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high on rst_i. Clock and reset are named clk_i / rst_i.
- Reset values: cdb_valid_o=0, cdb_data_o=0, cdb_src_o=0, RR pointer=0, starvation counter=0. eu_ready_o=0 while rst_i is high.
- Accept condition: acc = !cdb_valid_o | cdb_ready_i. Arbitration happens only when acc=1 and flush_i=0. Otherwise eu_ready_o=0.
- Grant: eu_ready_o[g]=1 for the winning channel g only. A transfer happens on eu_valid_i[g] & eu_ready_o[g]. eu_ready_o depends combinationally on eu_valid_i and state. EUs must hold data stable while valid and not granted.
- Latency: exactly 1 cycle. On the edge after a grant, cdb_valid_o=1, cdb_data_o=eu_data_i[g], cdb_src_o=g.
- Output with acc=1 and no request: cdb_valid_o goes to 0 next cycle.
- Output hold: while cdb_valid_o & !cdb_ready_i, cdb_data_o and cdb_src_o are held and no grant is issued.
- Back-to-back: cdb_ready_i held high gives one word per cycle.
- Priority: if PRIO_EN and eu_valid_i[PRIO_CH] and starve_force=0, g=PRIO_CH.
- Round-robin: otherwise g is the first valid channel at index >= RR pointer, wrapping modulo NUM_CH. PRIO_CH is also eligible in this search.
- RR pointer update: after any grant to a channel other than the priority channel, pointer = (g+1) mod NUM_CH, with wrap from NUM_CH-1 to 0. Unchanged on priority grants.
- Starvation counter (width $clog2(STARVE_MAX+1)):
  - Increments on a cycle where PRIO_CH is granted while some other channel is valid.
  - Saturates at STARVE_MAX.
  - Cleared on any non-priority grant and on flush_i.
- starve_force: starve_force = (counter == STARVE_MAX). When set, PRIO_CH is excluded from that arbitration.
- Flush: on flush_i, next cycle cdb_valid_o=0 and the counter is 0. The RR pointer is kept. eu_ready_o=0 during the flush cycle. flush_i has precedence over cdb_ready_i and any request.
- Reset has precedence over flush_i.
- Single valid channel: it is granted regardless of pointer or counter.
- No other state. No combinational path from cdb_ready_i to cdb_data_o.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, all eu_valid_i=0 -> cdb_valid_o=0, eu_ready_o=0, cdb_src_o=0 throughout.
- Round-robin, NUM_CH=6, PRIO_EN=0: channels 0,2,5 valid continuously, cdb_ready_i=1 -> grants 0,2,5,0,2,5.
  - cdb_src_o follows one cycle later.
  - rob_idx on the CDB matches each channel's data.
- Priority plus starvation, PRIO_CH=1, STARVE_MAX=4: channels 1 and 3 valid continuously -> grants 1,1,1,1,3,1,1,1,1,3.
  - Counter reaches 4, then clears after each grant to channel 3.
- Backpressure: channel 2 valid, data rob_idx=5; cdb_ready_i=0 for 3 cycles.
  - -> cdb_valid_o=1 with rob_idx=5 held stable, eu_ready_o=0 for those cycles.
  - -> on cdb_ready_i=1, the next word is granted in the same cycle.
- Flush mid-stream: output valid with rob_idx=7, cdb_ready_i=0, flush_i pulsed 1 cycle -> next cycle cdb_valid_o=0, eu_ready_o=0 during flush, RR order continues from the saved pointer.
- Wrap and single requester: pointer=5 (NUM_CH=6), only channel 0 valid -> channel 0 granted, pointer becomes 1. Then only channel 4 valid -> channel 4 granted, pointer becomes 5.
